dm_sized: RTL

Parametrised data memory, the successor to the single-cycle word-only data memory for the multi-cycle CPU. Supports byte, halfword and word access, with sign or zero extension on loads. Uses a req/ready handshake with a configurable number of wait states, and reports misaligned, reserved-size and out-of-range accesses through a fault flag. Sits between the CPU memory stage and the word-organised storage array.

---
 rtl/dm_pkg.sv | 11 +
 rtl/dm_sized_if.sv | 8 +
 rtl/dm_lane_align.sv | 20 ++
 rtl/dm_sized.sv | 81 ++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: access-size encodings, FSM states and the alignment check shared by the data memory.
package dm_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return (size == SZ_HALF && addr_lo[0]) || (size == SZ_WORD && addr_lo != 2'b00);
  endfunction
endpackage

// File: rtl/dm_sized_if.sv
// dm_sized_if: memory-stage bus; master drives req/mem_write/size/load_unsigned/address/data_in, slave returns data_out/ready/fault.
interface dm_sized_if;
  logic req, mem_write, load_unsigned, ready, fault;
  logic [1:0] size;
  logic [31:0] address, data_in, data_out;
  modport master(output req, mem_write, size, load_unsigned, address, data_in, input data_out, ready, fault);
  modport slave(input req, mem_write, size, load_unsigned, address, data_in, output data_out, ready, fault);
endinterface

// File: rtl/dm_lane_align.sv
// dm_lane_align: byte-lane steering; in size/addr_lo/load_unsigned/wdata/rdata, out be/wword (lane-replicated store)/lword (extended load).
module dm_lane_align import dm_pkg::*; (
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        load_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] lword
);
  logic [31:0] sh;
  assign sh = rdata >> {addr_lo, 3'b000};
  assign be = size == SZ_BYTE ? 4'b0001 << addr_lo :
              size == SZ_HALF ? 4'b0011 << {addr_lo[1], 1'b0} :
              size == SZ_WORD ? 4'b1111 : 4'b0000;
  assign wword = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
  assign lword = size == SZ_BYTE ? {{24{~load_unsigned & sh[7]}}, sh[7:0]} :
                 size == SZ_HALF ? {{16{~load_unsigned & sh[15]}}, sh[15:0]} : rdata;
endmodule

// File: rtl/dm_sized.sv
// dm_sized: sized data memory with wait states and fault flag; ports clock, reset_n (async low), bus (dm_sized_if.slave).
module dm_sized import dm_pkg::*; #(
  parameter int DEPTH = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic  clock,
  input logic  reset_n,
  dm_sized_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  state_t state;
  logic [3:0] cnt;
  logic we_q, lu_q, ready, fault, idle, bad, commit, c_we, c_lu;
  logic [1:0] size_q, c_size;
  logic [IDX_W+1:0] addr_q, c_addr;
  logic [IDX_W-1:0] idx;
  logic [31:0] din_q, c_din, data_out, rword, wword, lword;
  logic [3:0] be;
  logic [31:0] mem [DEPTH];
  assign idle = state == IDLE;
  assign bad = bus.size == SZ_RSVD || is_misaligned(bus.size, bus.address[1:0]) ||
               32'(bus.address[31:2]) >= 32'(DEPTH);
  assign c_we = idle ? bus.mem_write : we_q;
  assign c_lu = idle ? bus.load_unsigned : lu_q;
  assign c_size = idle ? bus.size : size_q;
  assign c_addr = idle ? bus.address[IDX_W+1:0] : addr_q;
  assign c_din = idle ? bus.data_in : din_q;
  assign idx = c_addr[IDX_W+1:2];
  assign rword = mem[idx];
  assign commit = idle ? bus.req && !bad && WAIT_STATES == 0 : state == WAIT && cnt == 4'd1;
  assign bus.data_out = data_out;
  assign bus.ready = ready;
  assign bus.fault = fault;
  dm_lane_align u_align (
    .size(c_size), .addr_lo(c_addr[1:0]), .load_unsigned(c_lu),
    .wdata(c_din), .rdata(rword), .be(be), .wword(wword), .lword(lword)
  );
  always_ff @(posedge clock)
    if (commit && c_we && reset_n)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= 4'd0;
      ready <= 1'b0;
      fault <= 1'b0;
      data_out <= '0;
      we_q <= 1'b0;
      lu_q <= 1'b0;
      size_q <= 2'b00;
      addr_q <= '0;
      din_q <= '0;
    end else begin
      ready <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: if (bus.req) begin
          we_q <= bus.mem_write;
          lu_q <= bus.load_unsigned;
          size_q <= bus.size;
          addr_q <= bus.address[IDX_W+1:0];
          din_q <= bus.data_in;
          cnt <= 4'(WAIT_STATES);
          state <= bad || commit ? DONE : WAIT;
          ready <= bad || commit;
          fault <= bad;
          if (!bus.mem_write && (bad || commit)) data_out <= bad ? '0 : lword;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (commit) begin
            state <= DONE;
            ready <= 1'b1;
            if (!we_q) data_out <= lword;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
